// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared types, field positions and command decode for the SPI register controller
package spi_ctrl_pkg;

    localparam int K_DWIDTH_DEF   = 16;
    localparam int K_AWIDTH_DEF   = 7;
    localparam int K_CMD_RW_BIT   = K_DWIDTH_DEF - 1;
    localparam int K_STAT_OVR_BIT = K_DWIDTH_DEF - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_WR_BUS,
        S_RD_REQ,
        S_RD_WAIT
    } state_t;

    typedef struct packed {
        logic                    rw;
        logic [K_AWIDTH_DEF-1:0] addr;
    } cmd_t;

    function automatic cmd_t cmd_decode(input logic [K_DWIDTH_DEF-1:0] w);
        return '{rw: w[K_CMD_RW_BIT], addr: w[K_AWIDTH_DEF-1:0]};
    endfunction

endpackage

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes the first SPI word of a frame as a command and streams burst register writes/reads
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rx_*, i_selected    received word stream and registered chip-select from the SPI slave
//   o_tx_data/o_tx_valid  next word to shift out and its load strobe
//   o_bus_* / i_bus_*     register bus request/ack handshake
//   o_busy, o_overrun     frame in progress, sticky dropped-word flag
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int K_DWIDTH = K_DWIDTH_DEF,
    parameter int K_AWIDTH = K_AWIDTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [K_DWIDTH-1:0] i_rx_data,
    input  logic                i_rx_event,
    input  logic                i_selected,
    output logic [K_DWIDTH-1:0] o_tx_data,
    output logic                o_tx_valid,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [K_AWIDTH-1:0] o_bus_addr,
    output logic [K_DWIDTH-1:0] o_bus_wdata,
    input  logic                i_bus_ack,
    input  logic [K_DWIDTH-1:0] i_bus_rdata,
    output logic                o_busy,
    output logic                o_overrun
);

    state_t state;
    logic   sel_q;
    logic   rx;
    cmd_t   cmd;

    assign rx  = i_rx_event & i_selected;
    assign cmd = cmd_decode(i_rx_data);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            sel_q       <= 1'b0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            sel_q      <= i_selected;
            o_tx_valid <= 1'b0;
            // a deselected frame finishes any outstanding bus cycle silently before idling
            if (state != S_IDLE && !i_selected) begin
                if (!o_bus_req || i_bus_ack) begin
                    state     <= S_IDLE;
                    o_busy    <= 1'b0;
                    o_bus_req <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: if (i_selected && !sel_q) begin
                        o_tx_data  <= K_DWIDTH'(o_overrun) << K_STAT_OVR_BIT;
                        o_tx_valid <= 1'b1;
                        o_overrun  <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_CMD;
                    end
                    S_CMD: if (rx) begin
                        o_bus_we   <= cmd.rw;
                        o_bus_addr <= cmd.addr;
                        o_bus_req  <= !cmd.rw;
                        state      <= cmd.rw ? S_WR_DATA : S_RD_REQ;
                    end
                    S_WR_DATA: if (rx) begin
                        o_bus_wdata <= i_rx_data;
                        o_bus_req   <= 1'b1;
                        state       <= S_WR_BUS;
                    end
                    S_WR_BUS: begin
                        if (rx) o_overrun <= 1'b1;
                        if (i_bus_ack) begin
                            o_bus_req  <= 1'b0;
                            o_bus_addr <= o_bus_addr + 1'b1;
                            state      <= S_WR_DATA;
                        end
                    end
                    S_RD_REQ: begin
                        if (rx) o_overrun <= 1'b1;
                        if (i_bus_ack) begin
                            o_bus_req  <= 1'b0;
                            o_tx_data  <= i_bus_rdata;
                            o_tx_valid <= 1'b1;
                            o_bus_addr <= o_bus_addr + 1'b1;
                            state      <= S_RD_WAIT;
                        end
                    end
                    S_RD_WAIT: if (rx) begin
                        o_bus_req <= 1'b1;
                        state     <= S_RD_REQ;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: table-driven cycle vectors plus directed overrun, deselect and reset sequences
module tb_spi_reg_ctrl;

    typedef struct {
        logic        sel, rxe;
        logic [15:0] rxd;
        logic        ack;
        logic [15:0] rdata;
        logic        req, we;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic        txv;
        logic [15:0] txd;
        logic        busy, ovr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_data;
    logic        rx_event;
    logic        selected;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        bus_req;
    logic        bus_we;
    logic [6:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_event (rx_event),
        .i_selected (selected),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .o_bus_req  (bus_req),
        .o_bus_we   (bus_we),
        .o_bus_addr (bus_addr),
        .o_bus_wdata(bus_wdata),
        .i_bus_ack  (bus_ack),
        .i_bus_rdata(bus_rdata),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    function automatic logic [43:0] outs();
        return {bus_req, bus_we, bus_addr, bus_wdata, tx_valid, tx_data, busy, overrun};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic rxe, input logic [15:0] rxd, input logic ack,
                       input logic [15:0] rdata, input logic req, input logic we, input logic [6:0] addr,
                       input logic [15:0] wdata, input logic txv, input logic [15:0] txd,
                       input logic bsy, input logic ovr);
        vecs.push_back('{sel, rxe, rxd, ack, rdata, req, we, addr, wdata, txv, txd, bsy, ovr});
    endtask

    initial begin
        // write burst 8005: 1234 -> 5, 5678 -> 6
        add(1,0,16'h0000,0,16'h0000, 0,0,7'h00,16'h0000,1,16'h0000,1,0);
        add(1,1,16'h8005,0,16'h0000, 0,1,7'h05,16'h0000,0,16'h0000,1,0);
        add(1,1,16'h1234,0,16'h0000, 1,1,7'h05,16'h1234,0,16'h0000,1,0);
        add(1,0,16'h0000,0,16'h0000, 1,1,7'h05,16'h1234,0,16'h0000,1,0);
        add(1,0,16'h0000,1,16'h0000, 0,1,7'h06,16'h1234,0,16'h0000,1,0);
        add(1,1,16'h5678,0,16'h0000, 1,1,7'h06,16'h5678,0,16'h0000,1,0);
        add(1,0,16'h0000,1,16'h0000, 0,1,7'h07,16'h5678,0,16'h0000,1,0);
        add(0,0,16'h0000,0,16'h0000, 0,1,7'h07,16'h5678,0,16'h0000,0,0);
        // read burst 0010: AAAA from 16, BBBB from 17
        add(1,0,16'h0000,0,16'h0000, 0,1,7'h07,16'h5678,1,16'h0000,1,0);
        add(1,1,16'h0010,0,16'h0000, 1,0,7'h10,16'h5678,0,16'h0000,1,0);
        add(1,0,16'h0000,0,16'h0000, 1,0,7'h10,16'h5678,0,16'h0000,1,0);
        add(1,0,16'h0000,1,16'hAAAA, 0,0,7'h11,16'h5678,1,16'hAAAA,1,0);
        add(1,0,16'h0000,0,16'h0000, 0,0,7'h11,16'h5678,0,16'hAAAA,1,0);
        add(1,1,16'hFFFF,0,16'h0000, 1,0,7'h11,16'h5678,0,16'hAAAA,1,0);
        add(1,0,16'h0000,1,16'hBBBB, 0,0,7'h12,16'h5678,1,16'hBBBB,1,0);
        add(0,0,16'h0000,0,16'h0000, 0,0,7'h12,16'h5678,0,16'hBBBB,0,0);
        // address wrap 7F -> 00
        add(1,0,16'h0000,0,16'h0000, 0,0,7'h12,16'h5678,1,16'h0000,1,0);
        add(1,1,16'h807F,0,16'h0000, 0,1,7'h7F,16'h5678,0,16'h0000,1,0);
        add(1,1,16'h0001,0,16'h0000, 1,1,7'h7F,16'h0001,0,16'h0000,1,0);
        add(1,0,16'h0000,1,16'h0000, 0,1,7'h00,16'h0001,0,16'h0000,1,0);
        add(1,1,16'h0002,0,16'h0000, 1,1,7'h00,16'h0002,0,16'h0000,1,0);
        add(1,0,16'h0000,1,16'h0000, 0,1,7'h01,16'h0002,0,16'h0000,1,0);
        add(0,0,16'h0000,0,16'h0000, 0,1,7'h01,16'h0002,0,16'h0000,0,0);
        // stray ack and deselected rx are ignored
        add(0,0,16'h0000,1,16'hDEAD, 0,1,7'h01,16'h0002,0,16'h0000,0,0);
        add(0,1,16'h8003,0,16'h0000, 0,1,7'h01,16'h0002,0,16'h0000,0,0);

        rst = 1'b1; rx_data = '0; rx_event = 1'b0; selected = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        step();
        step();
        chk("reset_outs", 64'(outs()), 64'h0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            selected = vecs[i].sel; rx_event = vecs[i].rxe; rx_data = vecs[i].rxd;
            bus_ack = vecs[i].ack; bus_rdata = vecs[i].rdata;
            step();
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     vecs[i].txv, vecs[i].txd, vecs[i].busy, vecs[i].ovr}));
        end
        rx_event = 1'b0; bus_ack = 1'b0; selected = 1'b0;

        // overrun during a slow write
        begin
            logic bad = 1'b0;
            selected = 1'b1; step();
            chk("ovr_stat0", 64'({tx_valid, tx_data}), 64'h1_0000);
            rx_event = 1'b1; rx_data = 16'h8003; step();
            rx_data = 16'h1111; step();
            chk("ovr_req", 64'({bus_req, bus_we, bus_addr, bus_wdata}), 64'({2'b11, 7'h03, 16'h1111}));
            for (int i = 0; i < 40; i++) begin
                rx_event = (i == 5); rx_data = 16'h2222;
                step();
                if (!bus_req || bus_wdata !== 16'h1111) bad = 1'b1;
            end
            rx_event = 1'b0;
            chk("ovr_hold", 64'(bad), 64'h0);
            chk("ovr_flag", 64'(overrun), 64'h1);
            bus_ack = 1'b1; step(); bus_ack = 1'b0;
            chk("ovr_ack", 64'({bus_req, bus_addr, bus_wdata}), 64'({1'b0, 7'h04, 16'h1111}));
            selected = 1'b0; step();
            chk("ovr_sticky", 64'({busy, overrun}), 64'h1);
            selected = 1'b1; step();
            chk("ovr_stat1", 64'({tx_valid, tx_data, overrun}), 64'({1'b1, 16'h8000, 1'b0}));
            selected = 1'b0; step();
        end

        // deselect with a read outstanding
        selected = 1'b1; step();
        rx_event = 1'b1; rx_data = 16'h0020; step();
        rx_event = 1'b0; selected = 1'b0;
        chk("dsl_req", 64'({bus_req, bus_we, bus_addr}), 64'({2'b10, 7'h20}));
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("dsl_hold%0d", i), 64'({bus_req, busy, tx_valid}), 64'b110);
        end
        bus_ack = 1'b1; bus_rdata = 16'hCCCC; step(); bus_ack = 1'b0;
        chk("dsl_done", 64'({bus_req, tx_valid, busy, tx_data}), 64'h0);
        step();
        chk("dsl_idle", 64'({busy, tx_valid}), 64'h0);

        // reset in the middle of a write bus cycle
        selected = 1'b1; step();
        rx_event = 1'b1; rx_data = 16'h8040; step();
        rx_data = 16'hBEEF; step();
        rx_data = 16'h0000; step();
        rx_event = 1'b0;
        chk("rst_pre", 64'({bus_req, overrun}), 64'b11);
        rst = 1'b1; step();
        chk("rst_outs", 64'(outs()), 64'h0);
        rst = 1'b0; step();
        chk("rst_stat", 64'({tx_valid, tx_data, busy}), 64'({1'b1, 16'h0000, 1'b1}));
        selected = 1'b0; step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
